bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Sits between the adder/sum datapath and the per-digit 7-segment decoders.
//   The downstream decoders then need only a 4-bit 0-9 digit each, not a full
//   value table. Provides a START/BUSY/DONE handshake and a leading-zero flag
//   so that unused upper digits can be blanked.
// PARAMETERS
//   WIDTH   6   binary input width in bits (default covers sums 0..63)
//   DIGITS  2   number of BCD digits produced; max displayable value 10^DIGITS-1
// PORTS
//   CLOCK_50  in   1            system clock, rising edge
//   RESET     in   1            asynchronous reset, active-high
//   START     in   1            request conversion of BIN; sampled on clock edge
//   BIN       in   WIDTH        unsigned binary value; captured when START is accepted
//   BUSY      out  1            high while a conversion is in progress
//   DONE      out  1            one-cycle pulse when BCD/OVF/LZ have just updated
//   BCD       out  4*DIGITS     result; digit i at [4i+3:4i], digit 0 = ones
//   OVF       out  1            captured BIN > 10^DIGITS-1; BCD saturated to all 9s
//   LZ        out  DIGITS-1     LZ[i]=1: digit i+1 and all digits above it are zero
// BEHAVIOUR
//   Reset: all outputs are 0 (BUSY, DONE, BCD, OVF, LZ). LZ then reads all-ones-
//     equivalent only after the first conversion. State goes to IDLE.
//   The reset is asynchronous: it takes effect mid-conversion without waiting
//     for a clock edge. Partial results are discarded.
//   States: IDLE -> SHIFT -> FINISH -> IDLE.
//   IDLE:
//     - START=1 at edge k: capture BIN into the shift register and clear the
//       BCD scratch register.
//     - Load count = WIDTH. Go to SHIFT. BUSY is high from edge k.
//   SHIFT, each cycle:
//     - Add 3 to every scratch digit that is >= 5.
//     - Then shift {scratch, shiftreg} left by 1 and decrement count.
//     - When count reaches 0, go to FINISH. This takes exactly WIDTH cycles.
//   FINISH, at edge k+WIDTH+1:
//     - Register the outputs: BCD, OVF, LZ. DONE=1 for this one cycle.
//     - BUSY=0. Next state is IDLE.
//   Latency: START accepted at edge k -> DONE high and result valid after edge
//     k+WIDTH+1. Default: 7 clocks.
//   BCD, OVF and LZ hold their values until the next FINISH. They never show
//     intermediate scratch values.
//   START while BUSY is ignored: no queueing, no restart.
//   START while DONE is high: not accepted, because the state is FINISH.
//     Re-issue START in IDLE. Minimum issue interval is WIDTH+2 clocks.
//   Scratch width: 4*DIGITS + 1 bits. The extra top bit catches overflow.
//     OVF=1 if the extra bit is set or any digit is >9 after the final shift.
//     On OVF, BCD is forced to all 9s.
//   WIDTH=1 is legal (latency 2). DIGITS must be >= 1. When DIGITS=1, LZ is
//     unused and tied to 0.
//   BIN changing while BUSY has no effect on the conversion in progress.
// TESTING
//   1 Reset, then START with BIN=0 -> DONE at the 7th edge after START;
//     BCD=8'h00, OVF=0, LZ=1.
//   2 BIN=37 (6'b100101) -> BCD=8'h37, LZ=0, OVF=0. BUSY high for exactly
//     7 cycles: 6 SHIFT cycles plus FINISH.
//   3 BIN=63 -> BCD=8'h63. Immediately pulse START again with BIN=9 while
//     BUSY -> ignored. Issue it again in IDLE -> BCD=8'h09, LZ=1.
//   4 Override WIDTH=7, DIGITS=2, BIN=127 -> OVF=1, BCD=8'h99.
//     BIN=99 -> OVF=0, BCD=8'h99. BIN=100 -> OVF=1.
//   5 Assert RESET 3 cycles into a BIN=45 conversion -> outputs clear
//     asynchronously and DONE never pulses. A fresh START with BIN=45 after
//     reset -> BCD=8'h45.
//   6 Exhaustive sweep of BIN=0..63 against a $display reference model:
//     BCD == {BIN/10, BIN%10}, LZ == (BIN<10), and DONE is exactly
//     one cycle wide.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// It uses a START/BUSY/DONE handshake and gives saturating overflow and leading-zero flags.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2,
  localparam int LZW   = (DIGITS > 1) ? DIGITS - 1 : 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [WIDTH-1:0]      BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  OVF,
  output logic [LZW-1:0]        LZ
);

  localparam int SW = 4 * DIGITS + 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [SW-1:0]   scratch;
  logic [SW-1:0]   adj;
  logic [WIDTH-1:0] shreg;
  logic            lost;
  logic            load, shift, finish;
  logic            ovf_fin;
  logic [4*DIGITS-1:0] bcd_fin;

  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++)
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic any_gt9(input logic [4*DIGITS-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4*DIGITS-1:0] sat_bcd(input logic [4*DIGITS-1:0] v,
                                                 input logic ovf);
    logic [4*DIGITS-1:0] r;
    r = v;
    if (ovf)
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  function automatic logic [LZW-1:0] lead_zeros(input logic [4*DIGITS-1:0] v);
    logic [LZW-1:0] z;
    z = '0;
    for (int i = 0; i < DIGITS - 1; i++)
      z[i] = ((v >> (4 * (i + 1))) == '0);
    return z;
  endfunction

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (START) begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (count == CW'(1)) state_nxt = FINISH;
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)      count <= '0;
    else if (load)  count <= CW'(WIDTH);
    else if (shift) count <= count - CW'(1);
  end

  // Conversion datapath: adjust then shift; a 1 leaving the top of scratch is remembered.
  assign adj = add3(scratch);

  always_ff @(posedge CLOCK_50) begin
    if (load) begin
      shreg   <= BIN;
      scratch <= '0;
      lost    <= 1'b0;
    end else if (shift) begin
      scratch <= {adj[SW-2:0], shreg[WIDTH-1]};
      shreg   <= shreg << 1;
      lost    <= lost | adj[SW-1];
    end
  end

  assign ovf_fin = lost | scratch[SW-1] | any_gt9(scratch[4*DIGITS-1:0]);
  assign bcd_fin = sat_bcd(scratch[4*DIGITS-1:0], ovf_fin);

  // Result stage: outputs change only on the FINISH edge.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      BUSY <= 1'b0;
      DONE <= 1'b0;
      BCD  <= '0;
      OVF  <= 1'b0;
      LZ   <= '0;
    end else begin
      BUSY <= (state_nxt != IDLE);
      DONE <= finish;
      if (finish) begin
        BCD <= bcd_fin;
        OVF <= ovf_fin;
        LZ  <= lead_zeros(bcd_fin);
      end
    end
  end

endmodule
